// File: rtl/data_mem_pkg.sv
// Shared definitions for the RV32I data-memory responder: funct3 codes,
// FSM states and the store byte-lane mask helper.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memState_t;

  function automatic logic [3:0] byteMask(input logic [2:0] funct3,
                                          input logic [1:0] addrLo);
    logic [3:0] mask;
    mask = '0;
    case (funct3)
      F3_B, F3_BU: mask = 4'b0001 << addrLo;
      F3_H, F3_HU: mask = addrLo[1] ? 4'b1100 : 4'b0011;
      F3_W:        mask = '1;
      default:     mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for the data-memory responder: replicates store
// data across lanes, builds the byte mask, extracts/extends load data, flags errors.
module load_store_align
  import data_mem_pkg::*;
(
  input  logic        iWrEn,
  input  logic [2:0]  iFunct3,
  input  logic [1:0]  iAddrLo,
  input  logic [31:0] iWrData,
  input  logic [31:0] iRamWord,
  output logic [31:0] oWrWord,
  output logic [3:0]  oByteMask,
  output logic [31:0] oLdData,
  output logic        oErr
);

  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  always_comb begin
    ldByte    = iRamWord[{iAddrLo, 3'b000} +: 8];
    ldHalf    = iAddrLo[1] ? iRamWord[31:16] : iRamWord[15:0];
    oErr      = 1'b0;
    oWrWord   = '0;
    oLdData   = '0;
    oByteMask = byteMask(iFunct3, iAddrLo);
    case (iFunct3)
      F3_B: begin
        oWrWord = {4{iWrData[7:0]}};
        oLdData = {{24{ldByte[7]}}, ldByte};
      end
      F3_H: begin
        oErr    = iAddrLo[0];
        oWrWord = {2{iWrData[15:0]}};
        oLdData = {{16{ldHalf[15]}}, ldHalf};
      end
      F3_W: begin
        oErr    = |iAddrLo;
        oWrWord = iWrData;
        oLdData = iRamWord;
      end
      // Unsigned sizes exist only for loads
      F3_BU: begin
        oErr    = iWrEn;
        oLdData = {24'b0, ldByte};
      end
      F3_HU: begin
        oErr    = iWrEn | iAddrLo[0];
        oLdData = {16'b0, ldHalf};
      end
      default: oErr = 1'b1;
    endcase
    if (oErr) begin
      oByteMask = '0;
      oLdData   = '0;
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: single-outstanding load/store over valid/ready with a
// fixed programmable wait before the RAM access commits.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq_Valid,
  output logic        oReq_Ready,
  input  logic        iWrEn,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic        oResp_Valid,
  output logic        oErr
);

  memState_t               state;
  logic [3:0]              cnt;
  logic                    capWrEn;
  logic [2:0]              capFunct3;
  logic [ADDR_WIDTH+1:0]   capAddr;
  logic [31:0]             capWrData;
  logic [31:0]             rdData;
  logic                    err;

  logic [31:0]             ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   wordIdx;
  logic                    commit;
  logic [31:0]             alignWrWord;
  logic [3:0]              alignMask;
  logic [31:0]             alignLdData;
  logic                    alignErr;

  // Address bits above the RAM depth are intentionally ignored (wrap)
  logic unusedAddrHi;
  assign unusedAddrHi = ^iAddr[31:ADDR_WIDTH+2];

  assign wordIdx     = capAddr[ADDR_WIDTH+1:2];
  assign commit      = (state == WAIT) && (cnt == '0);
  assign oReq_Ready  = (state == IDLE);
  assign oResp_Valid = (state == RESP);
  assign oRdData     = rdData;
  assign oErr        = err;

  load_store_align uAlign (
    .iWrEn     (capWrEn),
    .iFunct3   (capFunct3),
    .iAddrLo   (capAddr[1:0]),
    .iWrData   (capWrData),
    .iRamWord  (ram[wordIdx]),
    .oWrWord   (alignWrWord),
    .oByteMask (alignMask),
    .oLdData   (alignLdData),
    .oErr      (alignErr)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      cnt       <= '0;
      capWrEn   <= 1'b0;
      capFunct3 <= '0;
      capAddr   <= '0;
      capWrData <= '0;
      rdData    <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iReq_Valid) begin
            capWrEn   <= iWrEn;
            capFunct3 <= iFunct3;
            capAddr   <= iAddr[ADDR_WIDTH+1:0];
            capWrData <= iWrData;
            cnt       <= 4'(WAIT_CYCLES - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdData <= (capWrEn || alignErr) ? '0 : alignLdData;
            err    <= alignErr;
            state  <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          rdData <= '0;
          err    <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM contents survive reset; only the commit edge writes
  always_ff @(posedge iClk) begin
    if (commit && capWrEn && !alignErr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (alignMask[i]) ram[wordIdx][8*i +: 8] <= alignWrWord[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed scenarios plus randomized
// requests checked against a byte-level memory model.
module tb_data_mem_resp;

  localparam int unsigned AW = 8;
  localparam int unsigned WC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        wrEn;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        respValid;
  logic        err;

  int nAssert = 0;
  int nFail   = 0;

  bit [31:0] mem [2**AW];

  data_mem_resp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .iClk        (clk),
    .iRst        (rst),
    .iReq_Valid  (reqValid),
    .oReq_Ready  (reqReady),
    .iWrEn       (wrEn),
    .iFunct3     (funct3),
    .iAddr       (addr),
    .iWrData     (wrData),
    .oRdData     (rdData),
    .oResp_Valid (respValid),
    .oErr        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32I semantics on a byte-addressed view of the words
  function automatic void model(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] d, output bit expErr,
                                output bit [31:0] expRd);
    int unsigned size;
    int unsigned idx;
    int unsigned off;
    bit [63:0]   v;
    bit [63:0]   lim;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    if (size == 0) expErr = 1;
    else expErr = (f3[2] && size == 4) || (wr && f3[2]) || ((a % size) != 0);
    idx   = (a >> 2) % (2**AW);
    off   = a % 4;
    expRd = '0;
    if (!expErr) begin
      if (wr) begin
        for (int unsigned b = 0; b < size; b++)
          mem[idx][8*(off+b) +: 8] = d[8*b +: 8];
      end else begin
        lim = (64'd1 << (8*size)) - 64'd1;
        v   = ({32'b0, mem[idx]} >> (8*off)) & lim;
        if (!f3[2] && ((v >> (8*size-1)) & 64'd1) == 64'd1) v = v | ~lim;
        expRd = v[31:0];
      end
    end
  endfunction

  // Starts at a falling edge with the responder idle; ends one cycle after the response
  task automatic req(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                     input bit [31:0] d, output logic [31:0] rdOut, output logic errOut);
    bit        expErr;
    bit [31:0] expRd;
    bit        seen;
    int        lat;
    model(wr, f3, a, d, expErr, expRd);
    check("readyIdle", reqReady, 1);
    wrEn = wr; funct3 = f3; addr = a; wrData = d; reqValid = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    seen = 0; lat = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (respValid) begin
        seen = 1; lat = c;
      end else begin
        check("readyBusy", reqReady, 0);
      end
    end
    check("respSeen", seen, 1);
    check("latency", lat, WC + 1);
    check("rdData", rdData, expRd);
    check("err", err, expErr);
    rdOut = rdData; errOut = err;
    @(negedge clk);
    check("respOneCycle", respValid, 0);
    check("rdCleared", rdData, 0);
    check("errCleared", err, 0);
  endtask

  logic [31:0] r;
  logic        e;
  bit          sawResp;

  initial begin
    rst = 1'b1; reqValid = 1'b0; wrEn = 1'b0; funct3 = '0; addr = '0; wrData = '0;
    #23;
    check("rstReady", reqReady, 1);
    check("rstResp", respValid, 0);
    check("rstRd", rdData, 0);
    check("rstErr", err, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    for (int unsigned w = 0; w < 16; w++) req(1, 3'b010, 4*w, 32'h0, r, e);

    req(1, 3'b010, 32'h10, 32'h8000_00F0, r, e);
    check("swErr", e, 0);
    req(0, 3'b010, 32'h10, 0, r, e);
    check("lw10", r, 32'h8000_00F0);
    check("lw10Err", e, 0);

    req(1, 3'b000, 32'h12, 32'h0000_00AB, r, e);
    req(0, 3'b010, 32'h10, 0, r, e);
    check("lw10AfterSb", r, 32'h80AB_00F0);
    req(0, 3'b000, 32'h12, 0, r, e);
    check("lb12", r, 32'hFFFF_FFAB);
    req(0, 3'b100, 32'h12, 0, r, e);
    check("lbu12", r, 32'h0000_00AB);

    req(1, 3'b001, 32'h16, 32'h0000_7FFE, r, e);
    req(0, 3'b001, 32'h16, 0, r, e);
    check("lh16", r, 32'h0000_7FFE);
    req(0, 3'b101, 32'h14, 0, r, e);
    check("lhu14", r, 32'h0000_0000);

    req(0, 3'b001, 32'h11, 0, r, e);
    check("lhMisErr", e, 1);
    check("lhMisRd", r, 0);
    req(1, 3'b010, 32'h12, 32'hFFFF_FFFF, r, e);
    check("swMisErr", e, 1);
    req(1, 3'b100, 32'h10, 32'h1111_1111, r, e);
    check("sbuStoreErr", e, 1);
    req(0, 3'b010, 32'h10, 0, r, e);
    check("lw10Unchanged", r, 32'h80AB_00F0);
    req(0, 3'b011, 32'h10, 0, r, e);
    check("f3IllegalErr", e, 1);

    // Address wrap: bits above the RAM depth select the same word
    req(0, 3'b010, 32'hABCD_0410, 0, r, e);
    check("lwWrap", r, 32'h80AB_00F0);

    req(1, 3'b010, 32'h20, 32'h1234_5678, r, e);
    wrEn = 1'b1; funct3 = 3'b010; addr = 32'h20; wrData = 32'hDEAD_BEEF; reqValid = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midRstReady", reqReady, 1);
    check("midRstResp", respValid, 0);
    @(negedge clk); rst = 1'b0;
    sawResp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (respValid) sawResp = 1;
    end
    check("noRespAfterRst", sawResp, 0);
    req(0, 3'b010, 32'h20, 0, r, e);
    check("lw20Prior", r, 32'h1234_5678);

    for (int n = 0; n < 80; n++) begin
      bit        rw;
      bit [2:0]  rf;
      bit [31:0] ra;
      bit [31:0] rd;
      rw = 1'($urandom % 2);
      rf = 3'($urandom_range(0, 7));
      ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      rd = $urandom;
      req(rw, rf, ra, rd, r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder for the RV32I core: the far end of the load/store interface driven by the control unit's data write enable and funct3.
- Accepts one load or store request at a time over a valid/ready handshake.
- Stores: byte/half/word writes into a word-organised RAM, byte-lane masked. Loads: return sign- or zero-extended data after a fixed programmable wait.
- Sits between the datapath (ALU result as address, rs2 as store data) and the Basys3 block RAM; prepares the core for multi-cycle memory timing.

Parameters:
- ADDR_WIDTH, 8, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1, clock edges from request acceptance to access commit; legal range 1..15.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst  input  1  asynchronous active-high reset.
- iReq_Valid  input  1  request present.
- oReq_Ready  output  1  responder can accept; high only in IDLE.
- iWrEn  input  1  1 = store, 0 = load (data write enable from control unit).
- iFunct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- iAddr  input  32  byte address.
- iWrData  input  32  store data, right-aligned (rs2).
- oRdData  output  32  load result, extended; 0 for stores and errors.
- oResp_Valid  output  1  one-cycle response strobe.
- oErr  output  1  misaligned or illegal funct3; valid with oResp_Valid.

Behaviour:
- One clock, iClk; reset iRst is asynchronous, active-high.
- Reset: state IDLE, oResp_Valid=0, oErr=0, oRdData=0, wait counter=0. RAM contents are not reset.
- FSM states:
  - IDLE: oReq_Ready=1. If iReq_Valid is high at edge k, capture iWrEn, iFunct3, iAddr, iWrData, load counter with WAIT_CYCLES-1, go to WAIT.
  - WAIT: decrement counter each edge. When counter==0, the next edge commits the access and moves to RESP.
  - RESP: oResp_Valid=1 for exactly one cycle, then IDLE.
- Latency: accept at edge k; commit at edge k+WAIT_CYCLES; oResp_Valid high during the cycle after that edge. Next accept no earlier than edge k+WAIT_CYCLES+1.
- Word index = captured iAddr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo depth.
- Store lanes (funct3):
  - SB: lane = addr[1:0], data = iWrData[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1}, data = iWrData[15:0].
  - SW: all four lanes.
  - Unwritten lanes are preserved.
- Load extraction:
  - LB/LBU: byte at addr[1:0], sign/zero extended to 32 bits.
  - LH/LHU: half at addr[1], sign/zero extended.
  - LW: full word.
- Error conditions:
  - Half access with addr[0]=1: error.
  - Word access with addr[1:0]!=0: error.
  - funct3 outside the legal set, including 1xx for stores: error.
  - On error: no RAM write, oRdData=0, oErr=1 with the response.
- Outputs oRdData and oErr are registered and held from commit through the RESP cycle, then cleared to 0 on return to IDLE.
- iReq_Valid asserted outside IDLE is ignored and not queued; the requester must hold it until it sees oReq_Ready.
- Reset mid-operation: a store whose commit edge has not occurred is discarded, no response is issued, FSM returns to IDLE.

Decomposition:
- Shared package data_mem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state enum {IDLE, WAIT, RESP}.
  - Function computing the 4-bit byte mask from funct3 and addr[1:0].
- One combinational sub-module, load_store_align:
  - Inputs: funct3, addr[1:0], store data, RAM read word.
  - Outputs: lane-replicated write data, byte mask, extended load data, error flag.
- Top level holds the FSM, counter, capture registers and the RAM array.

Test Plan:
- Reset, then SW 0x8000_00F0 to addr 0x10, then LW addr 0x10 → rdata 0x8000_00F0, oErr=0. oResp_Valid exactly WAIT_CYCLES+1 cycles after each acceptance edge; oReq_Ready low meanwhile.
- After the above, SB 0xAB to addr 0x12, then LW 0x10 → 0x80AB_00F0. Then LB 0x12 → 0xFFFF_FFAB; LBU 0x12 → 0x0000_00AB.
- SH 0x7FFE to addr 0x16, then LH 0x16 → 0x0000_7FFE; LHU 0x14 → 0x0000_0000 (previously zeroed word).
- LH at 0x11 and SW at 0x12 → oErr=1, rdata 0. A follow-up LW 0x10 shows the word unchanged.
- Store funct3=100 → oErr=1, no write. Load funct3=011 → oErr=1.
- Reset during WAIT of an SW to 0x20 (WAIT_CYCLES=3, reset at cycle 1) → no oResp_Valid. Next LW 0x20 returns the prior contents.
